adaptive_frame_feeder: RTL and testbench
========================================

ADAPTIVE_FRAME_FEEDER -- requirements
Module: adaptive_frame_feeder

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 384, meaning bits per frame; legal values are multiples of 4.
REQ-002 SHALL have parameter SNR_W, default 8, meaning width of SNR metric and thresholds.
REQ-003 SHALL have parameter AW, default $clog2(FRAME_BITS), meaning bit-memory address width.
REQ-004 SHALL have port CLK_I  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RST_I  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  in  1  frame request; sampled only in IDLE.
REQ-007 SHALL have port snr  in  SNR_W  current SNR metric.
REQ-008 SHALL have port thr_hi  in  SNR_W  step-up threshold.
REQ-009 SHALL have port thr_lo  in  SNR_W  step-down threshold.
REQ-010 SHALL have port mem_addr  out  AW  bit-memory read address; read latency is 1 cycle.
REQ-011 SHALL have port mem_bit  in  1  bit read from the previous cycle's mem_addr.
REQ-012 SHALL have ports CYC_O, STB_O, WE_O  out  1 each  Wishbone-style master strobes.
REQ-013 SHALL have port DAT_O  out  4  symbol bits, MSB-aligned to bit bps-1; unused upper bits 0.
REQ-014 SHALL have port ACK_I  in  1  downstream acknowledge.
REQ-015 SHALL have port mode_o  out  2  active mode: 0=BPSK (bps=1), 1=QPSK (bps=2), 2=16QAM (bps=4).
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after the last symbol is ACKed.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SEND, DONE.
REQ-018 SHALL, in IDLE on start=1, update mode_o: if snr>=thr_hi, increment (saturate at 2); else if snr<thr_lo, decrement (saturate at 0); else hold; thr_hi takes precedence when both conditions hold.
REQ-019 SHALL change mode_o only on the IDLE->LOAD transition; mode is constant within a frame.
REQ-020 SHALL, in LOAD, issue bps consecutive addresses (one per cycle) and capture mem_bit one cycle later; the first captured bit goes to DAT_O[bps-1].
REQ-021 SHALL raise CYC_O, STB_O and WE_O together on the cycle after the last bit is captured; with start sampled at edge 0, STB_O is first high after edge bps+2.
REQ-022 SHALL hold STB_O and DAT_O stable until ACK_I=1 is sampled, then drop STB_O and return to LOAD for the next symbol.
REQ-023 SHALL keep CYC_O high from the first STB_O until the final ACK of the frame.
REQ-024 SHALL ignore ACK_I while STB_O=0.
REQ-025 SHALL send FRAME_BITS/bps symbols per frame (384/192/96 at the default), with mem_addr running 0..FRAME_BITS-1 and restarting at 0 each frame.
REQ-026 SHALL go to DONE after the final ACK, pulse frame_done for one cycle, then go to IDLE.
REQ-027 SHALL ignore start outside IDLE.

Reset
REQ-028 SHALL, on RST_I=1 at a clock edge, enter IDLE and clear CYC_O, STB_O, WE_O, DAT_O, mem_addr, mode_o and frame_done, including mid-frame; the partial frame is discarded.

Configuration
REQ-029 SHALL support macro FEEDER_LOOP_EN; when it is defined, DONE pulses frame_done, re-evaluates mode per REQ-018 and enters LOAD directly with mem_addr=0 (continuous frames); when it is undefined, DONE returns to IDLE and awaits start.

Verification
REQ-030 SHALL verify: mode_o=0, snr=200, thr_hi=150, thr_lo=50, start pulse, ACK_I always 1 -> mode_o=1, 192 symbols, first STB_O after edge 4, one frame_done pulse.
REQ-031 SHALL verify: mode_o=1, snr=100 (between thresholds) -> mode_o stays 1; snr=200 on the next start -> mode_o=2, 96 symbols, DAT_O equals 4 memory bits MSB-first.
REQ-032 SHALL verify: mode_o=2, snr=40 -> mode_o=1; repeat -> 0; repeat -> stays 0 (saturation); at mode_o=2 with snr=255 -> stays 2.
REQ-033 SHALL verify: ACK_I held low for 5 cycles on symbol 3 -> STB_O and DAT_O are stable throughout and mem_addr does not advance.
REQ-034 SHALL verify: RST_I asserted at symbol 50 -> on the next edge all outputs are 0 and state is IDLE; the next start begins again at mem_addr 0.
REQ-035 SHALL verify: with FEEDER_LOOP_EN defined, a single start -> frames run back-to-back, frame_done pulses every frame and mem_addr wraps to 0.

Source files
------------

// File: rtl/adaptive_frame_feeder.sv
// Adaptive-modulation frame feeder: reads a bit memory, packs BPSK/QPSK/16QAM symbols, ships them over a Wishbone-style master port.
// Optional FEEDER_LOOP_EN: frames run back-to-back after a single start instead of returning to IDLE.
module adaptive_frame_feeder #(
  parameter int unsigned FRAME_BITS = 384,
  parameter int unsigned SNR_W      = 8,
  parameter int unsigned AW         = $clog2(FRAME_BITS)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             start,
  input  logic [SNR_W-1:0] snr,
  input  logic [SNR_W-1:0] thr_hi,
  input  logic [SNR_W-1:0] thr_lo,
  output logic [AW-1:0]    mem_addr,
  input  logic             mem_bit,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  output logic [3:0]       DAT_O,
  input  logic             ACK_I,
  output logic [1:0]       mode_o,
  output logic             frame_done
);

  localparam int unsigned CNT_W     = 3;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [3:0]       sh_q, sh_d;
  logic [3:0]       dat_q, dat_d;
  logic             stb_q, stb_d;
  logic             cyc_q, cyc_d;
  logic             done_q, done_d;
  logic             last_q, last_d;

  logic [1:0]       mode_nxt_c;
  logic [CNT_W-1:0] bps_c;

  // Mode step decision; the step-up threshold wins when both conditions hold
  always_comb begin
    mode_nxt_c = mode_q;
    if (snr >= thr_hi) begin
      if (mode_q != 2'd2) mode_nxt_c = mode_q + 2'd1;
    end else if (snr < thr_lo) begin
      if (mode_q != 2'd0) mode_nxt_c = mode_q - 2'd1;
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    bps_c = CNT_W'(1);
      2'd1:    bps_c = CNT_W'(2);
      default: bps_c = CNT_W'(4);
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      addr_q  <= '0;
      lcnt_q  <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      lcnt_q  <= lcnt_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  // LOAD: cycles 0..bps-1 issue addresses, 1..bps capture mem_bit, bps+1 presents the symbol
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    lcnt_d  = lcnt_q;
    sh_d    = sh_q;
    dat_d   = dat_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode_nxt_c;
          lcnt_d  = '0;
          sh_d    = '0;
          last_d  = 1'b0;
        end
      end

      S_LOAD: begin
        lcnt_d = lcnt_q + CNT_W'(1);
        if (lcnt_q < bps_c) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            last_d = 1'b1;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        if ((lcnt_q != '0) && (lcnt_q <= bps_c)) begin
          sh_d = {sh_q[2:0], mem_bit};
        end
        if (lcnt_q == (bps_c + CNT_W'(1))) begin
          state_d = S_SEND;
          dat_d   = sh_q;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          lcnt_d  = '0;
        end
      end

      S_SEND: begin
        if (ACK_I) begin
          stb_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
            cyc_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            lcnt_d  = '0;
            sh_d    = '0;
          end
        end
      end

      S_DONE: begin
`ifdef FEEDER_LOOP_EN
        state_d = S_LOAD;
        mode_d  = mode_nxt_c;
        lcnt_d  = '0;
        sh_d    = '0;
        last_d  = 1'b0;
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr   = addr_q;
  assign CYC_O      = cyc_q;
  assign STB_O      = stb_q;
  assign WE_O       = stb_q;
  assign DAT_O      = dat_q;
  assign mode_o     = mode_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_adaptive_frame_feeder.sv
// Directed self-checking bench for adaptive_frame_feeder with a 1-cycle-latency bit memory model.
module tb_adaptive_frame_feeder;

  localparam int unsigned FB = 384;
  localparam int unsigned AW = 9;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic          start;
  logic [7:0]    snr, thr_hi, thr_lo;
  logic [AW-1:0] mem_addr;
  logic          mem_bit;
  logic          CYC_O, STB_O, WE_O;
  logic [3:0]    DAT_O;
  logic          ACK_I;
  logic [1:0]    mode_o;
  logic          frame_done;

  logic mem [0:FB-1];
  int tests = 0;
  int fails = 0;

  int nsym, ndone, first_stb, dat_err, mode_err, cyc_err;
  logic fd_after;

  adaptive_frame_feeder #(.FRAME_BITS(FB), .SNR_W(8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .snr(snr), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .mem_addr(mem_addr), .mem_bit(mem_bit), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .DAT_O(DAT_O), .ACK_I(ACK_I), .mode_o(mode_o), .frame_done(frame_done)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) mem_bit <= mem[mem_addr];

  function automatic int bps_of(input logic [1:0] m);
    return (m == 2'd0) ? 1 : ((m == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [3:0] exp_dat(input int base, input int bps);
    logic [3:0] d;
    d = '0;
    for (int k = 0; k < bps; k++) d[bps-1-k] = mem[(base + k) % FB];
    return d;
  endfunction

  task automatic step();
    @(posedge CLK_I);
    @(negedge CLK_I);
  endtask

  task automatic do_reset();
    @(negedge CLK_I);
    RST_I = 1'b1;
    start = 1'b0;
    step();
    RST_I = 1'b0;
  endtask

  // Pulse start, ACK every offered symbol, gather statistics until max_frames frame_done pulses
  task automatic run_frame(input logic [1:0] exp_mode, input int max_frames);
    int e, addr, bps;
    logic in_frame;
    nsym = 0; ndone = 0; first_stb = -1; dat_err = 0; mode_err = 0; cyc_err = 0;
    addr = 0; in_frame = 1'b0; bps = bps_of(exp_mode);
    ACK_I = 1'b1;
    @(negedge CLK_I);
    start = 1'b1;
    @(posedge CLK_I);
    e = 0;
    @(negedge CLK_I);
    start = 1'b0;
    while (e < 20000) begin
      if (mode_o !== exp_mode) mode_err++;
      if (in_frame && CYC_O !== 1'b1 && frame_done !== 1'b1) cyc_err++;
      if (STB_O === 1'b1) begin
        if (first_stb < 0) first_stb = e;
        in_frame = 1'b1;
        if (DAT_O !== exp_dat(addr, bps) || WE_O !== 1'b1) dat_err++;
        addr = (addr + bps) % FB;
        nsym++;
      end
      if (frame_done === 1'b1) begin
        ndone++;
        in_frame = 1'b0;
        if (ndone >= max_frames) break;
      end
      @(posedge CLK_I);
      e++;
      @(negedge CLK_I);
    end
    step();
    fd_after = frame_done;
  endtask

  task automatic check_frame(input string nm, input logic [1:0] m, input int syms, input int stb_edge);
    tests++; if (mode_o !== m) begin fails++; $display("FAIL %s_mode got %0d want %0d", nm, mode_o, m); end
    tests++; if (nsym !== syms) begin fails++; $display("FAIL %s_nsym got %0d want %0d", nm, nsym, syms); end
    tests++; if (first_stb !== stb_edge) begin fails++; $display("FAIL %s_first_stb got %0d want %0d", nm, first_stb, stb_edge); end
    tests++; if (ndone !== 1 || fd_after !== 1'b0) begin fails++; $display("FAIL %s_done got %0d/%0b want 1/0", nm, ndone, fd_after); end
    tests++; if (dat_err !== 0 || mode_err !== 0 || cyc_err !== 0) begin
      fails++; $display("FAIL %s_data got dat=%0d mode=%0d cyc=%0d errors want 0", nm, dat_err, mode_err, cyc_err);
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b1; start = 1'b0; ACK_I = 1'b1;
    snr = 8'd0; thr_hi = 8'd150; thr_lo = 8'd50;
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    tests++;
    if ({CYC_O, STB_O, WE_O, DAT_O, mem_addr, mode_o, frame_done} !== '0) begin
      fails++; $display("FAIL reset_outputs got %0h want 0", {CYC_O, STB_O, WE_O, DAT_O, mem_addr, mode_o, frame_done});
    end
    RST_I = 1'b0;
  endtask

  task automatic test_step_up();
    snr = 8'd200;
    run_frame(2'd1, 1);
    check_frame("up01", 2'd1, 192, 4);
  endtask

  task automatic test_hold_then_up();
    snr = 8'd100;
    run_frame(2'd1, 1);
    check_frame("hold1", 2'd1, 192, 4);
    snr = 8'd200;
    run_frame(2'd2, 1);
    check_frame("up12", 2'd2, 96, 6);
    snr = 8'd255;
    run_frame(2'd2, 1);
    check_frame("sat2", 2'd2, 96, 6);
  endtask

  task automatic test_step_down();
    snr = 8'd40;
    run_frame(2'd1, 1);
    check_frame("dn21", 2'd1, 192, 4);
    run_frame(2'd0, 1);
    check_frame("dn10", 2'd0, 384, 3);
    run_frame(2'd0, 1);
    check_frame("sat0", 2'd0, 384, 3);
  endtask

  task automatic test_thresholds();
    snr = 8'd150;
    run_frame(2'd1, 1);
    check_frame("eq_hi", 2'd1, 192, 4);
    snr = 8'd50;
    run_frame(2'd1, 1);
    check_frame("eq_lo", 2'd1, 192, 4);
    thr_hi = 8'd10; thr_lo = 8'd100;
    run_frame(2'd2, 1);
    check_frame("prec", 2'd2, 96, 6);
    thr_hi = 8'd150; thr_lo = 8'd50;
  endtask

  // Mode 2 frame: stall ACK on symbol 3 (bits 12..15) and check the bus holds
  task automatic test_ack_stall();
    int sym, cyc, stab_err;
    logic [3:0] d0;
    logic [AW-1:0] a0;
    snr = 8'd100; ACK_I = 1'b0; sym = 0; cyc = 0; stab_err = 0;
    @(negedge CLK_I); start = 1'b1;
    step(); start = 1'b0;
    while (sym < 3 && cyc < 200) begin
      ACK_I = STB_O;
      if (STB_O === 1'b1) sym++;
      step(); cyc++;
    end
    ACK_I = 1'b0;
    while (STB_O !== 1'b1 && cyc < 200) begin step(); cyc++; end
    d0 = DAT_O; a0 = mem_addr;
    tests++; if (d0 !== exp_dat(12, 4)) begin fails++; $display("FAIL stall_dat got %0h want %0h", d0, exp_dat(12, 4)); end
    repeat (5) begin
      step();
      if (STB_O !== 1'b1 || CYC_O !== 1'b1 || DAT_O !== d0 || mem_addr !== a0) stab_err++;
    end
    tests++; if (stab_err !== 0) begin fails++; $display("FAIL stall_hold got %0d unstable cycles want 0", stab_err); end
    ACK_I = 1'b1;
    step();
    ACK_I = 1'b0;
    tests++; if (STB_O !== 1'b0 || CYC_O !== 1'b1) begin fails++; $display("FAIL stall_release got stb=%0b cyc=%0b want 0/1", STB_O, CYC_O); end
    do_reset();
  endtask

  // Mode 0 frame reset at symbol 50, with a stray start mid-frame that must be ignored
  task automatic test_mid_reset();
    int sym, cyc;
    snr = 8'd100; ACK_I = 1'b0; sym = 0; cyc = 0;
    @(negedge CLK_I); start = 1'b1;
    step(); start = 1'b0;
    snr = 8'd200;
    while (sym < 50 && cyc < 1000) begin
      start = (sym > 10);
      ACK_I = STB_O;
      if (STB_O === 1'b1) sym++;
      step(); cyc++;
    end
    ACK_I = 1'b0;
    while (STB_O !== 1'b1 && cyc < 1000) begin step(); cyc++; end
    tests++; if (mode_o !== 2'd0 || STB_O !== 1'b1) begin fails++; $display("FAIL midstart_ignored got mode=%0d stb=%0b want 0/1", mode_o, STB_O); end
    start = 1'b0;
    RST_I = 1'b1;
    step();
    tests++;
    if ({CYC_O, STB_O, WE_O, DAT_O, mem_addr, mode_o, frame_done} !== '0) begin
      fails++; $display("FAIL midreset_outputs got %0h want 0", {CYC_O, STB_O, WE_O, DAT_O, mem_addr, mode_o, frame_done});
    end
    RST_I = 1'b0;
    repeat (3) step();
    tests++; if (STB_O !== 1'b0 || CYC_O !== 1'b0 || mem_addr !== '0) begin fails++; $display("FAIL midreset_idle got stb=%0b cyc=%0b addr=%0d want 0/0/0", STB_O, CYC_O, mem_addr); end
    snr = 8'd200;
    run_frame(2'd1, 1);
    check_frame("restart", 2'd1, 192, 4);
  endtask

`ifdef FEEDER_LOOP_EN
  task automatic test_loop();
    snr = 8'd100;
    run_frame(2'd0, 2);
    tests++; if (ndone !== 2) begin fails++; $display("FAIL loop_done got %0d want 2", ndone); end
    tests++; if (nsym !== 768) begin fails++; $display("FAIL loop_nsym got %0d want 768", nsym); end
    tests++; if (dat_err !== 0 || mode_err !== 0 || cyc_err !== 0) begin
      fails++; $display("FAIL loop_data got dat=%0d mode=%0d cyc=%0d errors want 0", dat_err, mode_err, cyc_err);
    end
    tests++; if (first_stb !== 3) begin fails++; $display("FAIL loop_first_stb got %0d want 3", first_stb); end
    do_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < FB; i++) mem[i] = 1'(((i * 7) + (i / 3)) >> 1);
    test_reset();
`ifdef FEEDER_LOOP_EN
    test_loop();
`else
    test_step_up();
    test_hold_then_up();
    test_step_down();
    test_thresholds();
    test_ack_stall();
    test_mid_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
